// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: SPI flash opcodes, status bit index, sequencer states and address byte helper
package spi_flash_pkg;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_DUMMY = 8'hFF;
  localparam int WIP_BIT = 0;
  localparam int GAP_W = 32;
  typedef enum logic [3:0] {
    ST_IDLE, ST_WREN, ST_GAP1, ST_SE, ST_GAP2, ST_RDSR, ST_CHECK, ST_POLL_GAP, ST_DONE, ST_ERR
  } state_t;
  function automatic logic [7:0] addr_byte(input logic [23:0] addr, input logic [1:0] idx);
    return idx == 2'd1 ? addr[23:16] : idx == 2'd2 ? addr[15:8] : addr[7:0];
  endfunction
endpackage

// File: rtl/spi_gap_timer.sv
// spi_gap_timer: loadable down-counter timing the CS-high gaps between SPI transactions
module spi_gap_timer
  import spi_flash_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [GAP_W-1:0] value,
  output logic             zero
);
  logic [GAP_W-1:0] cnt;
  // reload on request, otherwise count down and rest at zero
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= value;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0 && !load;
endmodule

// File: rtl/spi_erase_sequencer.sv
// spi_erase_sequencer: WREN, SE+addr, RDSR polling until WIP=0 over spi_drive; ERASE_TIMEOUT_EN adds a WIP timeout
module spi_erase_sequencer
  import spi_flash_pkg::*;
#(
`ifdef ERASE_TIMEOUT_EN
  parameter logic [31:0] TIMEOUT_CYC = 32'd150_000_000,
`endif
  parameter logic [7:0] SE_OPCODE = 8'hD8,
  parameter int CS_GAP_CYC = 10,
  parameter int POLL_GAP_CYC = 50
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        erase_req,
  input  logic [23:0] erase_addr,
  output logic        erase_busy,
  output logic        erase_done,
  output logic        erase_err,
  output logic [7:0]  status_reg,
  output logic        spi_start,
  output logic        spi_end,
  output logic [7:0]  data_send,
  input  logic [7:0]  data_rec,
  input  logic        send_done,
  input  logic        rec_done
);
  localparam logic [GAP_W-1:0] CS_LOAD = GAP_W'(CS_GAP_CYC - 1);
  localparam logic [GAP_W-1:0] POLL_LOAD = GAP_W'(POLL_GAP_CYC - 1);
  state_t state;
  logic [23:0] addr;
  logic [1:0] byte_cnt;
  logic rec_cnt, gap_load, gap_zero;
  logic [GAP_W-1:0] gap_value;
`ifdef ERASE_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic to_hit;
  assign to_hit = to_cnt >= TIMEOUT_CYC;
`else
  assign erase_err = 1'b0;
`endif
  spi_gap_timer u_gap (.clk(sys_clk), .rst(sys_rst), .load(gap_load), .value(gap_value), .zero(gap_zero));
  // erase sequencing FSM; every SPI control output is registered
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      state <= ST_IDLE;
      addr <= '0;
      byte_cnt <= '0;
      rec_cnt <= 1'b0;
      gap_load <= 1'b0;
      gap_value <= '0;
      erase_busy <= 1'b0;
      erase_done <= 1'b0;
      status_reg <= '0;
      spi_start <= 1'b0;
      spi_end <= 1'b0;
      data_send <= '0;
`ifdef ERASE_TIMEOUT_EN
      erase_err <= 1'b0;
      to_cnt <= '0;
`endif
    end else begin
      spi_start <= 1'b0;
      spi_end <= 1'b0;
      erase_done <= 1'b0;
      gap_load <= 1'b0;
`ifdef ERASE_TIMEOUT_EN
      erase_err <= 1'b0;
      to_cnt <= state == ST_SE ? '0 : to_cnt + 1'b1;
`endif
      case (state)
        ST_IDLE:
          if (erase_req) begin
            addr <= erase_addr;
            erase_busy <= 1'b1;
            spi_start <= 1'b1;
            data_send <= OP_WREN;
            state <= ST_WREN;
          end
        ST_WREN:
          if (send_done) begin
            spi_end <= 1'b1;
            gap_load <= 1'b1;
            gap_value <= CS_LOAD;
            state <= ST_GAP1;
          end
        ST_GAP1:
          if (gap_zero) begin
            spi_start <= 1'b1;
            data_send <= SE_OPCODE;
            byte_cnt <= '0;
            state <= ST_SE;
          end
        ST_SE:
          if (send_done && byte_cnt == 2'd3) begin
            spi_end <= 1'b1;
            gap_load <= 1'b1;
            gap_value <= CS_LOAD;
            state <= ST_GAP2;
          end else if (send_done) begin
            byte_cnt <= byte_cnt + 2'd1;
            data_send <= addr_byte(addr, byte_cnt + 2'd1);
          end
        ST_GAP2, ST_POLL_GAP:
`ifdef ERASE_TIMEOUT_EN
          if (state == ST_POLL_GAP && to_hit) begin
            erase_err <= 1'b1;
            erase_busy <= 1'b0;
            state <= ST_ERR;
          end else
`endif
          if (gap_zero) begin
            spi_start <= 1'b1;
            data_send <= OP_RDSR;
            byte_cnt <= '0;
            rec_cnt <= 1'b0;
            state <= ST_RDSR;
          end
        ST_RDSR: begin
          if (rec_done) rec_cnt <= 1'b1;
          if (rec_done && rec_cnt) status_reg <= data_rec;
          if (send_done && byte_cnt[0]) begin
            spi_end <= 1'b1;
            state <= ST_CHECK;
          end else if (send_done) begin
            byte_cnt <= 2'd1;
            data_send <= OP_DUMMY;
          end
        end
        ST_CHECK:
          if (!status_reg[WIP_BIT]) begin
            erase_done <= 1'b1;
            erase_busy <= 1'b0;
            state <= ST_DONE;
          end
`ifdef ERASE_TIMEOUT_EN
          else if (to_hit) begin
            erase_err <= 1'b1;
            erase_busy <= 1'b0;
            state <= ST_ERR;
          end
`endif
          else begin
            gap_load <= 1'b1;
            gap_value <= POLL_LOAD;
            state <= ST_POLL_GAP;
          end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_erase_sequencer.sv
// tb_spi_erase_sequencer: randomized bench with a behavioural byte engine and flash WIP model
module tb_spi_erase_sequencer;
  localparam int CS_GAP = 3;
  localparam int POLL_GAP = 7;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic erase_req = 1'b0;
  logic [23:0] erase_addr = '0;
  logic erase_busy, erase_done, erase_err, spi_start, spi_end;
  logic [7:0] status_reg, data_send;
  logic [7:0] data_rec = 8'h00;
  logic send_done = 1'b0;
  logic rec_done = 1'b0;
  int passed = 0, total = 0, fails = 0, cyc = 0;
  logic [7:0] mosi[$];
  int wip_left = 0, rdsr_cnt = 0, done_cnt = 0, err_cnt = 0, end_cnt = 0, viol = 0, gap_viol = 0;
  int last_end = -1, cnt = 0, bidx = 0;
  bit active = 0, nxt = 0;
  logic [7:0] cur = 8'h00, first = 8'h00, prev_first = 8'h00;

  spi_erase_sequencer #(
`ifdef ERASE_TIMEOUT_EN
    .TIMEOUT_CYC(32'd2000),
`endif
    .SE_OPCODE(8'hD8), .CS_GAP_CYC(CS_GAP), .POLL_GAP_CYC(POLL_GAP)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .erase_req(erase_req), .erase_addr(erase_addr),
    .erase_busy(erase_busy), .erase_done(erase_done), .erase_err(erase_err), .status_reg(status_reg),
    .spi_start(spi_start), .spi_end(spi_end), .data_send(data_send), .data_rec(data_rec),
    .send_done(send_done), .rec_done(rec_done)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // byte engine + flash: each byte takes a random 2..5 cycles; RDSR status reports WIP while wip_left > 0
  initial begin
    forever begin
      @(posedge sys_clk);
      #1;
      send_done = 1'b0;
      rec_done = 1'b0;
      if (erase_done) done_cnt++;
      if (erase_err) err_cnt++;
      if (spi_end) end_cnt++;
      if (spi_start && spi_end) viol++;
      if (sys_rst) begin
        active = 0;
        nxt = 0;
        cnt = 0;
      end else if (spi_start) begin
        if (active) viol++;
        if (last_end >= 0 && cyc - last_end < CS_GAP) gap_viol++;
        if (last_end >= 0 && data_send == 8'h05 && prev_first == 8'h05 && cyc - last_end < POLL_GAP) gap_viol++;
        if (data_send == 8'h05) rdsr_cnt++;
        active = 1;
        nxt = 0;
        bidx = 0;
        cur = data_send;
        first = data_send;
        cnt = $urandom_range(2, 5);
      end else if (spi_end) begin
        if (!active) viol++;
        active = 0;
        last_end = cyc;
        prev_first = first;
      end else if (active && nxt) begin
        cur = data_send;
        cnt = $urandom_range(2, 5);
        nxt = 0;
      end else if (active && cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          send_done = 1'b1;
          rec_done = 1'b1;
          data_rec = (first == 8'h05 && bidx == 1) ? (wip_left > 0 ? 8'h03 : 8'h00) : 8'h5A;
          if (first == 8'h05 && bidx == 1 && wip_left > 0) wip_left--;
          mosi.push_back(cur);
          bidx++;
          nxt = 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear(input int polls);
    mosi.delete();
    wip_left = polls;
    rdsr_cnt = 0;
    done_cnt = 0;
    err_cnt = 0;
    viol = 0;
    gap_viol = 0;
  endtask

  task automatic start_req(input logic [23:0] a);
    @(negedge sys_clk);
    erase_req = 1'b1;
    erase_addr = a;
    @(negedge sys_clk);
    erase_req = 1'b0;
    chk("busy_on_accept", erase_busy, 1);
  endtask

  task automatic wait_done(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge sys_clk);
      if (erase_done) ok = 1;
    end
  endtask

  task automatic finish_check(input string tag, input logic [23:0] a, input int polls);
    bit ok;
    logic [7:0] exp[$];
    wait_done(20000, ok);
    chk({tag, "_done_seen"}, ok, 1);
    chk({tag, "_busy_at_done"}, erase_busy, 0);
    chk({tag, "_status"}, status_reg, 8'h00);
    @(negedge sys_clk);
    chk({tag, "_done_width"}, erase_done, 0);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    exp = {8'h06, 8'hD8, a[23:16], a[15:8], a[7:0]};
    for (int i = 0; i <= polls; i++) begin
      exp.push_back(8'h05);
      exp.push_back(8'hFF);
    end
    chk({tag, "_mosi_len"}, mosi.size(), exp.size());
    for (int i = 0; i < exp.size() && i < mosi.size(); i++) chk({tag, "_mosi_byte"}, mosi[i], exp[i]);
    chk({tag, "_rdsr_cnt"}, rdsr_cnt, polls + 1);
    chk({tag, "_protocol"}, viol, 0);
    chk({tag, "_gaps"}, gap_viol, 0);
  endtask

  initial begin
    bit ok;
    int sz, ec, p, t0;
    logic [23:0] a;
    repeat (2) @(negedge sys_clk);
    chk("rst_busy", erase_busy, 0);
    chk("rst_done", erase_done, 0);
    chk("rst_err", erase_err, 0);
    chk("rst_start", spi_start, 0);
    chk("rst_end", spi_end, 0);
    chk("rst_data_send", data_send, 8'h00);
    chk("rst_status", status_reg, 8'h00);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    clear(0);
    start_req(24'h01_2345);
    finish_check("basic", 24'h01_2345, 0);
    clear(3);
    start_req(24'hAB_CDEF);
    finish_check("poll3", 24'hAB_CDEF, 3);
    for (int k = 0; k < 4; k++) begin
      a = 24'($urandom);
      p = $urandom_range(0, 4);
      clear(p);
      start_req(a);
      finish_check("rand", a, p);
    end
    clear(2);
    start_req(24'h10_0000);
    repeat (40) @(negedge sys_clk);
    erase_req = 1'b1;
    @(negedge sys_clk);
    erase_req = 1'b0;
    finish_check("ignore", 24'h10_0000, 2);
    sz = mosi.size();
    repeat (20) @(negedge sys_clk);
    chk("ignore_idle_busy", erase_busy, 0);
    chk("ignore_no_traffic", mosi.size(), sz);
    clear(1);
    @(negedge sys_clk);
    erase_req = 1'b1;
    erase_addr = 24'h20_1000;
    @(negedge sys_clk);
    chk("held_busy", erase_busy, 1);
    finish_check("held1", 24'h20_1000, 1);
    chk("held_idle_gap", erase_busy, 0);
    clear(0);
    @(negedge sys_clk);
    chk("held_restart", erase_busy, 1);
    erase_req = 1'b0;
    finish_check("held2", 24'h20_1000, 0);
    clear(0);
    start_req(24'h33_4455);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge sys_clk);
      if (mosi.size() >= 3) ok = 1;
    end
    chk("rst_mid_se_reached", ok, 1);
    sys_rst = 1'b1;
    ec = end_cnt;
    @(negedge sys_clk);
    chk("rst_mid_busy", erase_busy, 0);
    chk("rst_mid_start", spi_start, 0);
    chk("rst_mid_end", spi_end, 0);
    sys_rst = 1'b0;
    repeat (20) @(negedge sys_clk);
    chk("rst_mid_no_end", end_cnt, ec);
    chk("rst_mid_idle", erase_busy, 0);
    clear(1);
    start_req(24'h44_5566);
    finish_check("after_rst", 24'h44_5566, 1);
`ifdef ERASE_TIMEOUT_EN
    clear(1_000_000);
    start_req(24'h55_0000);
    t0 = cyc;
    ok = 0;
    for (int i = 0; i < 6000 && !ok; i++) begin
      @(negedge sys_clk);
      if (erase_err) ok = 1;
    end
    chk("to_err_seen", ok, 1);
    chk("to_err_late_enough", (cyc - t0) >= 2000, 1);
    chk("to_busy_at_err", erase_busy, 0);
    @(negedge sys_clk);
    chk("to_err_width", erase_err, 0);
    repeat (20) @(negedge sys_clk);
    chk("to_err_cnt", err_cnt, 1);
    chk("to_done_cnt", done_cnt, 0);
    chk("to_idle", erase_busy, 0);
`else
    clear(1_000_000);
    start_req(24'h55_0000);
    repeat (10000) @(negedge sys_clk);
    chk("stuck_err_cnt", err_cnt, 0);
    chk("stuck_done_cnt", done_cnt, 0);
    chk("stuck_busy", erase_busy, 1);
    chk("stuck_polling", rdsr_cnt > 100, 1);
    chk("stuck_protocol", viol, 0);
    chk("stuck_gaps", gap_viol, 0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    chk("stuck_rst_busy", erase_busy, 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
